piso_stream_serializer: RTL and testbench
=========================================

# piso_stream_serializer

Parametrised parallel-in/serial-out serializer with valid/ready handshakes on both sides. Accepts a WIDTH-bit word, then emits a run-time-selectable number of its low bits, one bit per accepted cycle, MSB-first or LSB-first. Serial-side backpressure is supported, and a new word can follow back-to-back with no bubble. It is the streaming successor to the fixed-order mux-based PISO and feeds serial links and bit-level protocol encoders in the design.

## Interface
- WIDTH, 8: parallel word width; legal range 2..64.
- CW, $clog2(WIDTH+1): width of frame_len and the internal bit counter; derived, never overridden.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset. Assertion is immediate; release is synchronous to clock.
- in_data  input  WIDTH  parallel word.
- in_valid  input  1  in_data, msb_first and frame_len are valid.
- in_ready  output  1  block can accept a word this cycle.
- msb_first  input  1  bit order, captured at load: 1 = MSB-first, 0 = LSB-first.
- frame_len  input  CW  number of bits to emit, captured at load. 0 or any value >WIDTH means WIDTH.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  downstream accepts ser_out this cycle.
- ser_last  output  1  ser_out is the final bit of the frame.
- busy  output  1  a frame is in progress; equal to ser_valid.

## Operation
- The block has two states: IDLE and SHIFT.
- IDLE:
  - in_ready=1, ser_valid=0, ser_out=0, ser_last=0.
  - On an edge with in_valid=1, capture in_data, msb_first and the effective length L (1..WIDTH). Load the bit counter with L and go to SHIFT.
- Frame content is always in_data[L-1:0]:
  - MSB-first emits in_data[L-1] down to in_data[0].
  - LSB-first emits in_data[0] up to in_data[L-1].
  - Bits above L-1 are ignored.
- SHIFT:
  - ser_valid=1 and ser_out is the current bit.
  - On an edge with ser_valid and ser_ready both high, advance to the next bit and decrement the counter.
  - ser_last=1 exactly while the counter equals 1.
  - When ser_valid and ser_ready are high and ser_last=0, stay in SHIFT.
  - When ser_valid, ser_ready and ser_last are all high (last bit accepted):
    - If in_valid=1, load the new word in the same edge and stay in SHIFT (back-to-back, no idle cycle).
    - If in_valid=0, go to IDLE.
- in_ready is combinational: (state==IDLE) or (ser_valid and ser_ready and ser_last). No other path from in_valid to in_ready.
- Backpressure: while ser_valid=1 and ser_ready=0, ser_out, ser_last and internal state hold unchanged for any number of cycles.
- in_data, msb_first and frame_len are sampled only on the load edge. Changes at any other time have no effect on the frame in progress.
- L=1: the first and only bit has ser_last=1 in its first cycle.
- Reset:
  - Values while reset_n is low: state IDLE, ser_valid=0, ser_out=0, ser_last=0, busy=0, in_ready=1.
  - Counter and data register clear to 0.
  - Reset mid-frame aborts the frame; no remaining bits are emitted after release.

## Timing
- Load-to-first-bit latency: 1 cycle. If a word is accepted at edge N, ser_valid=1 with the first bit after edge N.
- Throughput: 1 bit per cycle with ser_ready held high.
- Back-to-back frames: L1+L2 consecutive valid cycles with no gap.
- All outputs except in_ready are registered. in_ready depends combinationally on ser_ready.
- Frame duration: L accepted-bit edges, plus stall cycles.

## Test plan
- Reset, then in_data=8'hB4, msb_first=1, frame_len=0, ser_ready=1 -> ser_out 1,0,1,1,0,1,0,0 on 8 consecutive cycles. ser_last only on the 8th bit, then ser_valid=0 and in_ready=1.
- 8'hB4, msb_first=0, frame_len=8 -> 0,0,1,0,1,1,0,1. Then 8'hB4, frame_len=3: LSB-first gives 0,0,1 and MSB-first gives 1,0,0, each with ser_last on the 3rd bit. Then frame_len=1 -> a single bit with ser_last=1.
- Backpressure: 8'hB4 MSB-first with ser_ready low for 4 cycles after the 2nd bit -> ser_out=0 and ser_last=0 held stable through the stall. Full sequence still 1,0,1,1,0,1,0,0 with no bit lost or repeated.
- Back-to-back: in_valid held high with 8'hB4 (MSB-first) then 8'h0F (LSB-first) -> 16 contiguous valid bits 1,0,1,1,0,1,0,0,1,1,1,1,0,0,0,0. in_ready=1 in the last-bit cycle of the first frame.
- Reset mid-frame: assert reset_n=0 asynchronously after the 3rd bit -> ser_valid, ser_out and ser_last drop to 0 immediately with no clock edge, and in_ready=1. After release, no stale bits appear and the next load behaves as in the first test.
- Capture isolation: change in_data, msb_first and frame_len every cycle during a frame -> emitted bits match only the values present on the load edge.

Source files
------------

// File: rtl/piso_stream_serializer.sv
// ============================================================================
// Module      : piso_stream_serializer
// Description : Parallel-in/serial-out serializer with valid/ready on both
//               sides, run-time frame length and selectable bit order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_stream_serializer #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             msb_first,
    input  logic [CW-1:0]    frame_len,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_load_shift;
    logic             r_msb;
    logic             w_msb_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_len;
    logic             r_ser_out;
    logic             r_ser_last;
    logic             w_out_nxt;
    logic             w_last_nxt;
    logic             w_accept;
    logic             w_in_ready;
    logic             w_load;

    // Out-of-range lengths collapse to a full word.
    assign w_len = ((frame_len == '0) || (frame_len > C_WIDTH)) ? C_WIDTH : frame_len;

    // MSB-first frames are left-aligned so the first bit always sits at the top.
    assign w_load_shift = msb_first ? (in_data << (C_WIDTH - w_len)) : in_data;

    assign w_accept   = (r_state == S_SHIFT) & ser_ready;
    assign w_in_ready = (r_state == S_IDLE) | (w_accept & r_ser_last);
    assign w_load     = in_valid & w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_msb_nxt   = r_msb;
        w_cnt_nxt   = r_cnt;
        if (w_load) begin
            w_state_nxt = S_SHIFT;
            w_shift_nxt = w_load_shift;
            w_msb_nxt   = msb_first;
            w_cnt_nxt   = w_len;
        end else if (w_accept) begin
            w_shift_nxt = r_msb ? (r_shift << 1) : (r_shift >> 1);
            w_cnt_nxt   = r_cnt - C_ONE;
            if (r_ser_last) begin
                w_state_nxt = S_IDLE;
            end
        end
        w_out_nxt  = (w_state_nxt == S_SHIFT) &
                     (w_msb_nxt ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0]);
        w_last_nxt = (w_state_nxt == S_SHIFT) & (w_cnt_nxt == C_ONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= '0;
            r_msb      <= 1'b0;
            r_cnt      <= '0;
            r_ser_out  <= 1'b0;
            r_ser_last <= 1'b0;
        end else begin
            r_shift    <= w_shift_nxt;
            r_msb      <= w_msb_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ser_out  <= w_out_nxt;
            r_ser_last <= w_last_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign ser_out   = r_ser_out;
    assign ser_valid = (r_state == S_SHIFT);
    assign ser_last  = r_ser_last;
    assign busy      = (r_state == S_SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_piso_stream_serializer.sv
// ============================================================================
// Module      : tb_piso_stream_serializer
// Description : Directed self-checking bench for piso_stream_serializer with
//               a queue-based reference model of the expected bit stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_stream_serializer;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clock;
    logic             reset_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             msb_first;
    logic [CW-1:0]    frame_len;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    logic             busy;

    int nvec         = 0;
    int nerr         = 0;
    int load_count   = 0;
    int valid_cycles = 0;

    typedef struct packed {
        logic b;
        logic last;
    } ebit_t;

    ebit_t q[$];
    logic  mlog[$];

    bit    m_acc;
    bit    m_ld;
    int    m_len;
    logic  e_v, e_o, e_l, e_r;

    piso_stream_serializer #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msb_first (msb_first),
        .frame_len (frame_len),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Model: on each load, the frame's bits are queued in emission order.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
        end else begin
            m_acc = (q.size() > 0) && ser_ready;
            m_ld  = in_valid && ((q.size() == 0) || (m_acc && q[0].last));
            if (m_acc) begin
                mlog.push_back(q[0].b);
                void'(q.pop_front());
            end
            if (m_ld) begin
                m_len = ((frame_len == 0) || (int'(frame_len) > WIDTH)) ? WIDTH : int'(frame_len);
                for (int i = 0; i < m_len; i++) begin
                    q.push_back('{b: in_data[msb_first ? (m_len - 1 - i) : i],
                                  last: (i == m_len - 1)});
                end
                load_count++;
            end
        end
    end

    always @(negedge clock) begin
        e_v = (q.size() > 0);
        e_o = e_v ? q[0].b : 1'b0;
        e_l = e_v ? q[0].last : 1'b0;
        e_r = !e_v || (ser_ready && q[0].last);
        chk("ser_valid", 64'(ser_valid), 64'(e_v));
        chk("ser_out",   64'(ser_out),   64'(e_o));
        chk("ser_last",  64'(ser_last),  64'(e_l));
        chk("busy",      64'(busy),      64'(e_v));
        chk("in_ready",  64'(in_ready),  64'(e_r));
        if (ser_valid) valid_cycles++;
    end

    function automatic logic [63:0] packlog();
        logic [63:0] v = '0;
        foreach (mlog[i]) v = {v[62:0], mlog[i]};
        return v;
    endfunction

    task automatic expect_seq(input string name, input logic [63:0] exp, input int n);
        chk(name, packlog(), exp);
        chk({name, "_len"}, 64'(mlog.size()), 64'(n));
        mlog.delete();
    endtask

    task automatic load(input logic [WIDTH-1:0] d, input logic msb,
                        input logic [CW-1:0] len, input bit keep);
        int lc;
        bit ok;
        in_data   = d;
        msb_first = msb;
        frame_len = len;
        in_valid  = 1'b1;
        lc = load_count;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (load_count != lc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("load");
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit scramble);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (scramble) begin
                in_data   = WIDTH'($urandom);
                msb_first = 1'($urandom);
                frame_len = CW'($urandom);
            end
            @(posedge clock);
            #1;
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("wait_idle");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        msb_first = 1'b0;
        frame_len = '0;
        ser_ready = 1'b1;
        #2;
        chk("rst_ser_valid", 64'(ser_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Full-width MSB-first
        load(8'hB4, 1'b1, 4'd0, 1'b0);
        wait_idle(1'b0);
        expect_seq("msb8", 64'b10110100, 8);
        chk("idle_in_ready",  64'(in_ready),  64'd1);
        chk("idle_ser_valid", 64'(ser_valid), 64'd0);

        // LSB-first and short frames
        load(8'hB4, 1'b0, 4'd8, 1'b0);
        wait_idle(1'b0);
        expect_seq("lsb8", 64'b00101101, 8);
        load(8'hB4, 1'b0, 4'd3, 1'b0);
        wait_idle(1'b0);
        expect_seq("lsb3", 64'b001, 3);
        load(8'hB4, 1'b1, 4'd3, 1'b0);
        chk("msb3_first", 64'(ser_out), 64'd1);
        wait_idle(1'b0);
        expect_seq("msb3", 64'b100, 3);
        load(8'hB5, 1'b1, 4'd1, 1'b0);
        chk("len1_last", 64'(ser_last), 64'd1);
        chk("len1_bit",  64'(ser_out),  64'd1);
        wait_idle(1'b0);
        expect_seq("len1", 64'b1, 1);
        load(8'hB4, 1'b1, 4'd12, 1'b0);
        wait_idle(1'b0);
        expect_seq("len_over", 64'b10110100, 8);

        // Backpressure while the 2nd bit is presented
        load(8'hB4, 1'b1, 4'd0, 1'b0);
        @(posedge clock);
        #1 ser_ready = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("stall_out",   64'(ser_out),   64'd0);
            chk("stall_last",  64'(ser_last),  64'd0);
            chk("stall_valid", 64'(ser_valid), 64'd1);
        end
        @(posedge clock);
        #1 ser_ready = 1'b1;
        wait_idle(1'b0);
        expect_seq("stall_seq", 64'b10110100, 8);

        // Back-to-back frames with in_valid held high
        valid_cycles = 0;
        load(8'hB4, 1'b1, 4'd0, 1'b1);
        in_data   = 8'h0F;
        msb_first = 1'b0;
        repeat (7) begin
            @(posedge clock);
            #1;
        end
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        chk("b2b_last",     64'(ser_last), 64'd1);
        load(8'h0F, 1'b0, 4'd0, 1'b0);
        wait_idle(1'b0);
        expect_seq("b2b_seq", 64'b1011010011110000, 16);
        chk("b2b_valid_cycles", 64'(valid_cycles), 64'd16);

        // Asynchronous reset mid-frame
        load(8'hB4, 1'b1, 4'd0, 1'b0);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        expect_seq("pre_reset", 64'b101, 3);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid",    64'(ser_valid), 64'd0);
        chk("arst_out",      64'(ser_out),   64'd0);
        chk("arst_last",     64'(ser_last),  64'd0);
        chk("arst_busy",     64'(busy),      64'd0);
        chk("arst_in_ready", 64'(in_ready),  64'd1);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chk("post_rst_valid", 64'(ser_valid), 64'd0);
        chk("post_rst_bits",  64'(mlog.size()), 64'd0);
        load(8'hB4, 1'b1, 4'd0, 1'b0);
        wait_idle(1'b0);
        expect_seq("post_rst_seq", 64'b10110100, 8);

        // Inputs scrambled every cycle during a frame
        load(8'hB4, 1'b1, 4'd0, 1'b0);
        wait_idle(1'b1);
        expect_seq("iso_msb", 64'b10110100, 8);
        load(8'h0F, 1'b0, 4'd6, 1'b0);
        wait_idle(1'b1);
        expect_seq("iso_lsb", 64'b111100, 6);

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
